muldiv_unit: RTL and testbench

- Iterative RV64M multiply/divide unit on the execute side of the single-cycle datapath.
- Consumes the two register-file read operands (ReadData1 = rs1, ReadData2 = rs2) and returns a XLEN-bit result to the write-back path.
- Control stalls the PC while busy is high, then asserts RegWrite when done pulses.
- One result bit (multiply) or one quotient bit (divide) is produced per clock.

---
 rtl/muldiv_unit.sv | 134 +++++++++++++
 tb/tb_muldiv_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: one product or quotient bit per clock,
// sign correction in a final cycle, and special divide cases resolved at capture.
module muldiv_unit #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_t;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        fn;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic              neg_q, neg_r;

    logic              accept, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf, special;
    logic [XLEN-1:0]   mag_a, mag_b, special_res;

    always_comb begin
        accept      = (state == IDLE) && start && !kill;
        a_sgn       = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
        b_sgn       = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg       = a_sgn && op_a[XLEN-1];
        b_neg       = b_sgn && op_b[XLEN-1];
        // Negating the most-negative value wraps to itself, which is its correct unsigned magnitude.
        mag_a       = a_neg ? -op_a : op_a;
        mag_b       = b_neg ? -op_b : op_b;
        div_zero    = funct3[2] && (op_b == '0);
        div_ovf     = funct3[2] && !funct3[0] && (op_a == MOST_NEG) && (op_b == '1);
        special     = div_zero || div_ovf;
        special_res = '0;
        if (div_zero)
            special_res = funct3[1] ? op_a : '1;
        else if (!funct3[1])
            special_res = MOST_NEG;
    end

    // Multiply: acc = {partial sum, multiplier}; divide: acc = {remainder, dividend/quotient}.
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] acc_step, prod_fix;
    logic [XLEN-1:0]   q_fix, r_fix, fin_res;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc[0]}} & opnd};
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opnd};
        if (!fn[2])
            acc_step = {mul_sum, acc[XLEN-1:1]};
        else if (div_diff[XLEN])
            acc_step = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        else
            acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

        prod_fix = neg_q ? -acc : acc;
        q_fix    = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        r_fix    = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (fn)
            3'b000:                 fin_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fin_res = q_fix;
            default:                fin_res = r_fix;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = (state == DONE);
        case (state)
            IDLE:    if (accept) state_nx = special ? DONE : RUN;
            RUN:     if (cnt == CNT_W'(XLEN-1)) state_nx = FIN;
            FIN:     state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        if (kill && (state != IDLE))
            state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            fn     <= '0;
            acc    <= '0;
            opnd   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else begin
            if (accept) begin
                fn    <= funct3;
                cnt   <= '0;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                if (funct3[2]) begin
                    acc  <= {{XLEN{1'b0}}, mag_a};
                    opnd <= mag_b;
                end else begin
                    acc  <= {{XLEN{1'b0}}, mag_b};
                    opnd <= mag_a;
                end
                if (special)
                    result <= special_res;
            end else if (state == RUN) begin
                acc <= acc_step;
                cnt <= cnt + 1'b1;
            end
            if ((state == FIN) && !kill)
                result <= fin_res;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results are queued at issue and
// compared whenever done pulses; latency, kill, reset and busy-start are covered.
module tb_muldiv_unit;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [2:0]      funct3 = '0;
    logic [XLEN-1:0] op_a = '0;
    logic [XLEN-1:0] op_b = '0;
    logic            kill = 1'b0;
    logic            busy, done;
    logic [XLEN-1:0] result;

    int              n_cmp = 0;
    int              n_bad = 0;
    int              n_push = 0;
    int              n_done = 0;
    logic [63:0]     exp_q[$];
    string           tag_q[$];
    logic [63:0]     last_exp = '0;

    localparam logic [63:0] MNEG = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    muldiv_unit #(.XLEN(XLEN), .CNT_W(7)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            n_done++;
            if (exp_q.size() == 0)
                check("spurious_done", {63'b0, done}, 64'd0);
            else
                check(tag_q.pop_front(), result, exp_q.pop_front());
        end
    end

    // poke >= 0 re-asserts start with different operands that many edges after capture.
    task automatic do_op(input string tag, input logic [2:0] f, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int lat_exp,
                         input int poke);
        int n;
        @(negedge clk);
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        exp_q.push_back(exp); tag_q.push_back(tag); n_push++; last_exp = exp;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            if (n == poke) begin
                start = 1'b1; funct3 = 3'b000; op_a = ~a; op_b = b + 64'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check({tag, "_lat"}, 64'(n), 64'(lat_exp));
        @(posedge clk); #1;
        check({tag, "_pulse"}, {63'b0, done}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] ra, rb;
        #12;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_result", result, 64'd0);
        @(negedge clk); reset = 1'b1;

        do_op("mul",     3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, XLEN+1, -1);
        do_op("mulhu",   3'b011, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'd6, XLEN+1, -1);
        do_op("mulh",    3'b001, ONES, ONES, 64'd0, XLEN+1, -1);
        do_op("mulhsu",  3'b010, ONES, ONES, ONES, XLEN+1, -1);
        do_op("mulhu_b", 3'b011, MNEG, MNEG, 64'h4000_0000_0000_0000, XLEN+1, -1);
        do_op("div",     3'b100, -64'sd7, 64'd2, -64'sd3, XLEN+1, -1);
        do_op("rem",     3'b110, -64'sd7, 64'd2, ONES, XLEN+1, -1);
        do_op("divu",    3'b101, 64'd100, 64'd7, 64'd14, XLEN+1, -1);
        do_op("remu",    3'b111, 64'd100, 64'd7, 64'd2, XLEN+1, -1);
        do_op("div_z",   3'b100, 64'd5, 64'd0, ONES, 0, -1);
        do_op("divu_z",  3'b101, 64'd5, 64'd0, ONES, 0, -1);
        do_op("remu_z",  3'b111, 64'd5, 64'd0, 64'd5, 0, -1);
        do_op("rem_z",   3'b110, -64'sd5, 64'd0, -64'sd5, 0, -1);
        do_op("div_ovf", 3'b100, MNEG, ONES, MNEG, 0, -1);
        do_op("rem_ovf", 3'b110, MNEG, ONES, 64'd0, 0, -1);
        do_op("divu_mn", 3'b101, MNEG, ONES, 64'd0, XLEN+1, -1);
        do_op("busy_st", 3'b101, 64'd100, 64'd7, 64'd14, XLEN+1, 5);

        for (int i = 0; i < 6; i++) begin
            ra = {$urandom, $urandom};
            rb = {32'h0, $urandom} | 64'd1;
            case (i % 3)
                0: do_op("rnd_mul",  3'b000, ra, rb, ra * rb, XLEN+1, -1);
                1: do_op("rnd_divu", 3'b101, ra, rb, ra / rb, XLEN+1, -1);
                default: do_op("rnd_remu", 3'b111, ra, rb, ra % rb, XLEN+1, -1);
            endcase
        end

        // kill during RUN: no done, result keeps the last completed value
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op_a = 64'd3; op_b = 64'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_busy", {63'b0, busy}, 64'd0);
        check("kill_done", {63'b0, done}, 64'd0);
        check("kill_result", result, last_exp);
        repeat (80) @(posedge clk);

        // kill in IDLE drops a simultaneous start
        @(negedge clk);
        start = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check("idle_kill_busy", {63'b0, busy}, 64'd0);

        do_op("after_kill", 3'b000, 64'd6, 64'd9, 64'd54, XLEN+1, -1);

        // asynchronous reset mid-RUN
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op_a = 64'd7; op_b = 64'd11;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("amid_busy", {63'b0, busy}, 64'd0);
        check("amid_done", {63'b0, done}, 64'd0);
        check("amid_result", result, 64'd0);
        @(negedge clk); reset = 1'b1;
        repeat (80) @(posedge clk);

        do_op("post_rst", 3'b101, 64'd1000, 64'd10, 64'd100, XLEN+1, -1);

        @(negedge clk);
        check("done_count", 64'(n_done), 64'(n_push));
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
